// File: rtl/hazard_sched.sv
// hazard_sched: RAW-hazard, taken-branch flush and memory-wait freeze control for the 5-step core.
// Build option: define HAZARD_FWD_EN for the forwarding variant (only load-use hazards stall).
module hazard_sched #(
   parameter int unsigned REG_AW       = 5,
   parameter int unsigned FLUSH_CYCLES = 1,
   parameter int unsigned CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              dec_valid,
   input  logic [REG_AW-1:0] dec_rs,
   input  logic [REG_AW-1:0] dec_rt,
   input  logic              dec_use_rs,
   input  logic              dec_use_rt,
   input  logic              dec_rf_w,
   input  logic [REG_AW-1:0] dec_wn,
   input  logic              dec_is_load,
   input  logic              ex_branch_taken,
   input  logic              mem_wait,
   output logic              load_step1,
   output logic              load_step2,
   output logic              bubble_step3,
   output logic              flush_step2,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);
   localparam int unsigned FC_W = 2;

   typedef struct packed {
      logic              v;
      logic [REG_AW-1:0] wn;
   } sb_entry_t;

   typedef enum logic [1:0] {ST_RUN, ST_STALL, ST_FLUSH} state_t;

   state_t          state, state_nxt;
   logic [FC_W-1:0] frem, frem_nxt;
   sb_entry_t       s3, s4, s5;
   logic            raw;
   logic            stall_act;
   logic            flush_act;

   function automatic logic hit(sb_entry_t e, logic [REG_AW-1:0] src, logic use_src);
      return e.v && (e.wn == src) && (src != '0) && use_src;
   endfunction

`ifdef HAZARD_FWD_EN
   // Only a load still in step3 cannot be forwarded to the step2 consumer.
   logic s3_ld;
   logic unused_s5;
   assign unused_s5 = ^s5;

   always_comb begin
      raw = 1'b0;
      if (dec_valid && s3_ld)
         raw = hit(s3, dec_rs, dec_use_rs) || hit(s3, dec_rt, dec_use_rt);
   end
`else
   // No forwarding and no RF write-through: any in-flight writer blocks the read.
   logic unused_ld;
   assign unused_ld = dec_is_load;

   always_comb begin
      raw = 1'b0;
      if (dec_valid)
         raw = hit(s3, dec_rs, dec_use_rs) || hit(s3, dec_rt, dec_use_rt) ||
               hit(s4, dec_rs, dec_use_rs) || hit(s4, dec_rt, dec_use_rt) ||
               hit(s5, dec_rs, dec_use_rs) || hit(s5, dec_rt, dec_use_rt);
   end
`endif

   // Next state and action decode; mem_wait freezes everything.
   always_comb begin
      state_nxt = state;
      frem_nxt  = frem;
      flush_act = 1'b0;
      stall_act = 1'b0;
      if (!mem_wait) begin
         case (state)
            ST_FLUSH: begin
               flush_act = 1'b1;
               frem_nxt  = frem - FC_W'(1);
               if (frem <= FC_W'(1))
                  state_nxt = ST_RUN;
            end
            default: begin
               if (ex_branch_taken) begin
                  // The resolving cycle is itself the first squash cycle.
                  flush_act = 1'b1;
                  frem_nxt  = FC_W'(FLUSH_CYCLES - 1);
                  state_nxt = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
               end else if (raw) begin
                  stall_act = 1'b1;
                  state_nxt = ST_STALL;
               end else begin
                  state_nxt = ST_RUN;
               end
            end
         endcase
      end
   end

   // Reset forces the idle control values without waiting for a clock.
   assign load_step1   = ~reset | ~(mem_wait | stall_act);
   assign load_step2   = ~reset | ~(mem_wait | stall_act);
   assign bubble_step3 = reset & (stall_act | flush_act);
   assign flush_step2  = reset & flush_act;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_RUN;
         frem  <= '0;
      end else begin
         state <= state_nxt;
         frem  <= frem_nxt;
      end
   end

   // Scoreboard shift and saturating performance counters.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s3        <= '0;
         s4        <= '0;
         s5        <= '0;
         stall_cnt <= '0;
         flush_cnt <= '0;
`ifdef HAZARD_FWD_EN
         s3_ld     <= 1'b0;
`endif
      end else if (!mem_wait) begin
         s5    <= s4;
         s4    <= s3;
         s3.v  <= dec_valid & dec_rf_w & ~stall_act & ~flush_act & (dec_wn != '0);
         s3.wn <= dec_wn;
`ifdef HAZARD_FWD_EN
         s3_ld <= dec_is_load;
`endif
         if (stall_act && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_act && (flush_cnt != '1))
            flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: doc/hazard_sched.md
Name: hazard_sched

Overview:
- Pipeline hazard scheduler for the 5-step in-order core: step1 fetch, step2 decode, step3 execute, step4 memory, step5 writeback.
- Keeps a shadow scoreboard of in-flight destination registers for steps 3..5.
- Detects RAW hazards against the instruction in step2, handles taken-branch flushes and memory-wait freezes.
- Drives the per-step load/bubble controls consumed by the fsm_step* blocks.

Parameters:
- REG_AW, 5, register-number width.
- FLUSH_CYCLES, 1, cycles of wrong-path squash after a taken branch resolves in step3 (1..3).
- CNT_W, 16, width of the saturating stall/flush performance counters.

Ports:
- clk  in  1  core clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- dec_valid  in  1  step2 holds a real instruction.
- dec_rs  in  REG_AW  step2 source register 1.
- dec_rt  in  REG_AW  step2 source register 2.
- dec_use_rs  in  1  step2 reads rs.
- dec_use_rt  in  1  step2 reads rt.
- dec_rf_w  in  1  step2 instruction writes the RF (rf_w from fsm_step2).
- dec_wn  in  REG_AW  step2 destination register.
- dec_is_load  in  1  step2 instruction is LW.
- ex_branch_taken  in  1  branch in step3 resolved taken this cycle.
- mem_wait  in  1  step4 memory not ready; whole pipe must freeze.
- load_step1  out  1  PC/step1 register enable.
- load_step2  out  1  step2 register enable.
- bubble_step3  out  1  inject NOP into step3 (drives step3 reset path).
- flush_step2  out  1  squash step2 contents.
- stall_cnt  out  CNT_W  saturating count of RAW-stall cycles.
- flush_cnt  out  CNT_W  saturating count of flush cycles.

Behaviour:
- Scoreboard: 3 entries S3, S4, S5, each {v, wn, ld}.
  - Every non-frozen cycle: S5<=S4, S4<=S3.
  - S3 <= {dec_valid & dec_rf_w & ~stall & ~flush, dec_wn, dec_is_load}.
  - Entries with wn==0 are stored with v=0.
- Match on entry Sx: Sx.v & Sx.wn==src & src!=0 & use_src. Evaluated for rs and rt, step2 valid only.
- RAW stall (combinational, without forwarding): a match on any of S3, S4 or S5. The RF is not write-through, so S5 counts as a hazard.
- Controller FSM states:
  - RUN:
    - ex_branch_taken -> FLUSH, with the flush counter loaded to FLUSH_CYCLES-1.
    - Else a hazard -> STALL.
  - STALL:
    - Outputs: load_step1=0, load_step2=0, bubble_step3=1.
    - Leaves to RUN in the cycle the hazard clears; the outputs of that cycle are RUN outputs.
    - ex_branch_taken -> FLUSH.
  - FLUSH:
    - Outputs: flush_step2=1, bubble_step3=1, load_step1=1, load_step2=1.
    - Holds for FLUSH_CYCLES cycles total, then returns to RUN.
    - A new ex_branch_taken is impossible while bubbling and is ignored.
- Outputs in RUN with no event: load_step1=1, load_step2=1, bubble_step3=0, flush_step2=0.
- Priority: mem_wait > ex_branch_taken > RAW stall.
  - Branch plus hazard in the same cycle: flush only, no stall count.
- mem_wait=1:
  - Outputs: all loads 0, bubble_step3=0, flush_step2=0.
  - Scoreboard, FSM state and remaining flush count are frozen.
  - Counters do not increment.
  - The pending action resumes on the cycle mem_wait falls.
- Counters:
  - stall_cnt +1 per cycle with bubble_step3 due to RAW.
  - flush_cnt +1 per flush cycle.
  - Both saturate at all-ones.
- Reset (async, reset=0):
  - FSM=RUN, scoreboard v=0, counters=0.
  - Outputs: load_step1=1, load_step2=1, bubble_step3=0, flush_step2=0.
  - Reset mid-stall or mid-flush abandons the action immediately.

Optional Feature:
- HAZARD_FWD_EN defined: a forwarding network exists.
  - Only load-use stalls: a match on S3 with S3.ld=1. Maximum 1 stall cycle per hazard.
  - ALU results in S3/S4/S5 and loads in S4/S5 never stall.
- Undefined: full-interlock rule above (up to 3 stall cycles).

Test Plan:
- Reset then idle, dec_valid=0 -> load_step1=1, load_step2=1, bubble_step3=0, flush_step2=0, counters 0.
- ADDI r5 followed by ADD reading r5 (use_rs=1), no FWD -> 3 consecutive bubble_step3=1 cycles, then RUN; stall_cnt=3. With HAZARD_FWD_EN -> 0 stalls.
- LW r7 then SW using rt=r7 -> 3 stalls without FWD; exactly 1 stall with HAZARD_FWD_EN; a dependent on r0 -> 0 stalls in both builds.
- ex_branch_taken in the same cycle as a RAW hazard, FLUSH_CYCLES=2 -> flush_step2=1 for 2 cycles, stall_cnt unchanged, flush_cnt=2.
- mem_wait=1 for 4 cycles during STALL -> all loads 0, scoreboard/counters frozen; after release the stall completes with the original remaining count.
- Assert reset low mid-FLUSH -> outputs return to reset values asynchronously; flush_step2=0 immediately; counters 0.
